// File: rtl/mem_port_arbiter_if.sv
// ==================================================================
// mem_port_arbiter_if : requester, RAM and status bundle of the port arbiter
// Revision 1.0
// ==================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic [1:0]        cpustate;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              pnl_req;
  logic              pnl_we;
  logic [ADDR_W-1:0] pnl_addr;
  logic [DATA_W-1:0] pnl_wdata;
  logic              cpu_ack;
  logic              pnl_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [7:0]        conflict_cnt;

  // Arbiter side
  modport slave (
    input  cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  pnl_req, pnl_we, pnl_addr, pnl_wdata, mem_rdata,
    output cpu_ack, pnl_ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
    output busy, conflict_cnt
  );

  // Requesters plus RAM side
  modport master (
    output cpustate, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output pnl_req, pnl_we, pnl_addr, pnl_wdata, mem_rdata,
    input  cpu_ack, pnl_ack, rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  busy, conflict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ==================================================================
// mem_port_arbiter : round-robin CPU / front-panel arbiter for one RAM port
// Revision 1.0
// ==================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              owner_pnl;
  logic              last_pnl;
  logic              cpu_ack;
  logic              pnl_ack;
  logic              mem_rd;
  logic              mem_wr;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        conflict_cnt;

  logic              cpu_elig;
  logic              pnl_elig;
  logic              pick_pnl;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  // A halted CPU is invisible to arbitration; the panel is always served.
  assign cpu_elig    = bus.cpu_req && (bus.cpustate != 2'b00);
  assign pnl_elig    = bus.pnl_req;
  assign pick_pnl    = pnl_elig && (!cpu_elig || !last_pnl);
  assign grant_we    = pick_pnl ? bus.pnl_we    : bus.cpu_we;
  assign grant_addr  = pick_pnl ? bus.pnl_addr  : bus.cpu_addr;
  assign grant_wdata = pick_pnl ? bus.pnl_wdata : bus.cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner_pnl    <= 1'b0;
      last_pnl     <= 1'b1;
      cpu_ack      <= 1'b0;
      pnl_ack      <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata        <= '0;
      conflict_cnt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_elig && pnl_elig && (conflict_cnt != 8'hFF))
            conflict_cnt <= conflict_cnt + 8'd1;
          // mem_addr/mem_wdata double as the operand latch and hold afterwards
          if (cpu_elig || pnl_elig) begin
            owner_pnl <= pick_pnl;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
            mem_wr    <= grant_we;
            mem_rd    <= !grant_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM read data is sampled at the close of the access cycle
          if (mem_rd)
            rdata <= bus.mem_rdata;
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          cpu_ack <= !owner_pnl;
          pnl_ack <= owner_pnl;
          state   <= DONE;
        end
        DONE: begin
          cpu_ack  <= 1'b0;
          pnl_ack  <= 1'b0;
          last_pnl <= owner_pnl;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack      = cpu_ack;
  assign bus.pnl_ack      = pnl_ack;
  assign bus.rdata        = rdata;
  assign bus.mem_rd       = mem_rd;
  assign bus.mem_wr       = mem_wr;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.busy         = busy;
  assign bus.conflict_cnt = conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ==================================================================
// tb_mem_port_arbiter : vector table, directed corner cases and a random run against a timeline model
// Revision 1.0
// ==================================================================
`default_nettype none

module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM: combinational read, written on the edge that closes a write access
  logic [7:0] ram [0:255] = '{default: 8'h00};
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;
  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (pre_en)
      ram[pre_addr] <= pre_data;
    else if (bus.mem_wr)
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_cmp++;
      if ((bus.cpu_ack && bus.pnl_ack) || (bus.mem_rd && bus.mem_wr)) begin
        n_bad++;
        $display("FAIL exclusive: acks=%b%b rd/wr=%b%b, required never both high (cycle %0d)",
                 bus.cpu_ack, bus.pnl_ack, bus.mem_rd, bus.mem_wr, cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.cpustate  = 2'b00;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    bus.pnl_req   = 1'b0;
    bus.pnl_we    = 1'b0;
    bus.pnl_addr  = 16'h0000;
    bus.pnl_wdata = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  cs;
    logic        creq, cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        preq, pwe;
    logic [15:0] paddr;
    logic [7:0]  pwd;
    logic        pre;
    logic [7:0]  pa, pd;
    logic        erd, ewr;
    logic [15:0] eaddr;
    logic [7:0]  ewd;
    logic        ecack, epack;
    logic [7:0]  erdata;
  } vec_t;

  vec_t vecs [5];

  // Timeline reference model state
  logic [7:0]  mem_model [0:255] = '{default: 8'h00};
  int          g, free_at;
  logic        m_pnl, m_we, m_last_pnl, ce, pe;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata, m_cnt;

  task automatic new_cpu();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'($urandom);
    bus.cpu_addr  = {8'($urandom), 2'b11, 6'($urandom)};
    bus.cpu_wdata = 8'($urandom);
  endtask

  task automatic new_pnl();
    bus.pnl_req   = 1'b1;
    bus.pnl_we    = 1'($urandom);
    bus.pnl_addr  = {8'($urandom), 2'b11, 6'($urandom)};
    bus.pnl_wdata = 8'($urandom);
  endtask

  initial begin
    int cnt;
    int last_ack;
    int w;

    vecs[0] = '{2'b00, 1'b1, 1'b0, 16'h0050, 8'h00, 1'b1, 1'b1, 16'h0010, 8'hA5,
                1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 16'h0003, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                1'b1, 8'h03, 8'h3C, 1'b1, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{2'b01, 1'b1, 1'b1, 16'h0044, 8'h11, 1'b1, 1'b0, 16'h0055, 8'h99,
                1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0044, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{2'b00, 1'b1, 1'b1, 16'h0066, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00,
                1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{2'b11, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0080, 8'h5A,
                1'b1, 8'h80, 8'h7E, 1'b1, 1'b0, 16'h0080, 8'h5A, 1'b0, 1'b1, 8'h7E};

    // Reset state
    do_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_acks", 32'({bus.cpu_ack, bus.pnl_ack}), 32'd0);
    check("rst_rdwr", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_cnt", 32'(bus.conflict_cnt), 32'd0);

    // Single transactions from a fresh reset
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = vecs[i];
      do_reset();
      if (v.pre) begin
        pre_en = 1'b1; pre_addr = v.pa; pre_data = v.pd;
        tick();
        pre_en = 1'b0;
      end
      bus.cpustate = v.cs;
      bus.cpu_req = v.creq; bus.cpu_we = v.cwe; bus.cpu_addr = v.caddr; bus.cpu_wdata = v.cwd;
      bus.pnl_req = v.preq; bus.pnl_we = v.pwe; bus.pnl_addr = v.paddr; bus.pnl_wdata = v.pwd;
      tick();
      check($sformatf("v%0d_rd", i), 32'(bus.mem_rd), 32'(v.erd));
      check($sformatf("v%0d_wr", i), 32'(bus.mem_wr), 32'(v.ewr));
      check($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(v.eaddr));
      check($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata), 32'(v.ewd));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(v.erd | v.ewr));
      tick();
      check($sformatf("v%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'(v.ecack));
      check($sformatf("v%0d_pnl_ack", i), 32'(bus.pnl_ack), 32'(v.epack));
      check($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(v.erdata));
      idle_inputs();
      tick();
      tick();
    end

    // Tie held from reset: CPU first, then alternate, one ack every 3 cycles
    do_reset();
    bus.cpustate = 2'b01;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 8'h21;
    bus.pnl_req = 1'b1; bus.pnl_we = 1'b1; bus.pnl_addr = 16'h0200; bus.pnl_wdata = 8'h42;
    last_ack = 0;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!(bus.cpu_ack || bus.pnl_ack) && w < 6) begin
        tick();
        w++;
      end
      check($sformatf("tie%0d_ack_seen", k), 32'(bus.cpu_ack | bus.pnl_ack), 32'd1);
      check($sformatf("tie%0d_owner_pnl", k), 32'(bus.pnl_ack), 32'(k % 2));
      check($sformatf("tie%0d_cnt", k), 32'(bus.conflict_cnt), 32'(k + 1));
      if (k > 0) check($sformatf("tie%0d_spacing", k), 32'(cyc - last_ack), 32'd3);
      last_ack = cyc;
      tick();
    end
    // Keep holding both until the counter must have saturated
    for (int i = 0; i < 810; i++) tick();
    check("sat_cnt", 32'(bus.conflict_cnt), 32'hFF);
    tick();
    tick();
    tick();
    check("sat_hold", 32'(bus.conflict_cnt), 32'hFF);

    // Halted CPU never granted; releasing halt grants it 2 cycles later
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0005;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_rd || bus.mem_wr || bus.busy) cnt++;
    end
    check("halt_no_activity", 32'(cnt), 32'd0);
    bus.cpustate = 2'b01;
    tick();
    tick();
    check("halt_release_ack", 32'(bus.cpu_ack), 32'd1);
    idle_inputs();
    tick();
    tick();

    // Reset during the access cycle aborts without an ack
    do_reset();
    bus.pnl_req = 1'b1; bus.pnl_we = 1'b1; bus.pnl_addr = 16'h0020; bus.pnl_wdata = 8'hEE;
    tick();
    check("rma_in_access", 32'(bus.mem_wr), 32'd1);
    rst = 1'b1;
    tick();
    check("rma_rdwr", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    check("rma_busy", 32'(bus.busy), 32'd0);
    check("rma_acks", 32'({bus.cpu_ack, bus.pnl_ack}), 32'd0);
    check("rma_addr", 32'(bus.mem_addr), 32'd0);
    check("rma_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b0;
    bus.pnl_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_ack || bus.pnl_ack || bus.busy) cnt++;
    end
    check("rma_no_late_ack", 32'(cnt), 32'd0);

    // Request withdrawn after grant still completes
    do_reset();
    bus.pnl_req = 1'b1; bus.pnl_we = 1'b0; bus.pnl_addr = 16'h0030;
    tick();
    bus.pnl_req = 1'b0;
    tick();
    check("withdraw_ack", 32'(bus.pnl_ack), 32'd1);
    tick();
    tick();

    // CPU halted mid-access: completes, then no further CPU grant
    do_reset();
    bus.cpustate = 2'b01;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0007;
    tick();
    bus.cpustate = 2'b00;
    tick();
    check("halt_mid_ack", 32'(bus.cpu_ack), 32'd1);
    tick();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy || bus.mem_rd || bus.mem_wr) cnt++;
    end
    check("halt_mid_no_regrant", 32'(cnt), 32'd0);

    // Random traffic against a timeline model (addresses kept in 0xC0-0xFF of the RAM)
    do_reset();
    g = -100; free_at = 0; m_last_pnl = 1'b1; m_pnl = 1'b0; m_we = 1'b0;
    m_addr = 16'h0000; m_wdata = 8'h00; m_rdata = 8'h00; m_cnt = 8'h00;
    for (int e = 0; e < 3000; e++) begin
      @(posedge clk);
      if (e == g + 1) begin
        if (m_we) mem_model[m_addr[7:0]] = m_wdata;
        else      m_rdata = mem_model[m_addr[7:0]];
      end
      if (e >= free_at) begin
        ce = bus.cpu_req && (bus.cpustate != 2'b00);
        pe = bus.pnl_req;
        if (ce && pe && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (ce || pe) begin
          m_pnl      = pe && (!ce || !m_last_pnl);
          m_last_pnl = m_pnl;
          m_we       = m_pnl ? bus.pnl_we : bus.cpu_we;
          m_addr     = m_pnl ? bus.pnl_addr : bus.cpu_addr;
          m_wdata    = m_pnl ? bus.pnl_wdata : bus.cpu_wdata;
          g          = e;
          free_at    = e + 3;
        end
      end
      #1;
      cyc++;
      check("rnd_wr", 32'(bus.mem_wr), 32'((e == g) && m_we));
      check("rnd_rd", 32'(bus.mem_rd), 32'((e == g) && !m_we));
      check("rnd_busy", 32'(bus.busy), 32'((e == g) || (e == g + 1)));
      check("rnd_cpu_ack", 32'(bus.cpu_ack), 32'((e == g + 1) && !m_pnl));
      check("rnd_pnl_ack", 32'(bus.pnl_ack), 32'((e == g + 1) && m_pnl));
      check("rnd_addr", 32'(bus.mem_addr), 32'(m_addr));
      check("rnd_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      check("rnd_rdata", 32'(bus.rdata), 32'(m_rdata));
      check("rnd_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));

      if (bus.cpu_ack) begin
        if ($urandom % 2 == 0) new_cpu(); else bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom % 3 == 0) begin
        new_cpu();
      end
      if (bus.pnl_ack) begin
        if ($urandom % 2 == 0) new_pnl(); else bus.pnl_req = 1'b0;
      end else if (!bus.pnl_req && $urandom % 3 == 0) begin
        new_pnl();
      end
      if ($urandom % 16 == 0) bus.cpustate = 2'($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
- REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
- REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
- REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port cpustate, input, 2, run mode from the switch controller; 2'b00 = halted.
- REQ-006 SHALL have ports cpu_req, cpu_we, input, 1 each: CPU access request and write flag.
- REQ-007 SHALL have ports cpu_addr (ADDR_W) and cpu_wdata (DATA_W), inputs.
- REQ-008 SHALL have ports pnl_req, pnl_we, input, 1 each: front-panel (switch load/check) request and write flag.
- REQ-009 SHALL have ports pnl_addr (ADDR_W) and pnl_wdata (DATA_W), inputs.
- REQ-010 SHALL have ports cpu_ack and pnl_ack, output, 1 each: one-cycle completion pulse.
- REQ-011 SHALL have port rdata, output, DATA_W: registered read data, valid in the ack cycle.
- REQ-012 SHALL have ports mem_rd, mem_wr (1), mem_addr (ADDR_W), mem_wdata (DATA_W), outputs to the RAM.
- REQ-013 SHALL have port mem_rdata, input, DATA_W, RAM read data, valid one cycle after mem_rd.
- REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
- REQ-015 SHALL have port conflict_cnt, output, 8: saturating count of cycles where both requests were present in IDLE.

Function
- REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
- REQ-017 IDLE: with no eligible request, stay in IDLE; mem_rd=mem_wr=0.
- REQ-018 Eligibility: pnl_req always eligible; cpu_req eligible only when cpustate != 2'b00.
- REQ-019 One eligible request: grant it, latch its addr/wdata/we and owner, go to ACCESS.
- REQ-020 Both eligible: grant the requester not granted last (round-robin via last_owner flag; last_owner=panel after reset, so CPU wins the first tie).
- REQ-021 ACCESS (exactly one cycle): drive mem_addr/mem_wdata from latch; mem_wr=latched we, mem_rd=!latched we; go to DONE.
- REQ-022 DONE (exactly one cycle): register mem_rdata into rdata for reads (rdata unchanged for writes); pulse owner's ack for one cycle; update last_owner; go to IDLE.
- REQ-023 Latency: request sampled in IDLE at edge N -> ack high in cycle N+2; back-to-back accesses every 3 cycles.
- REQ-024 Requesters SHALL hold req and operands stable until ack; the arbiter samples operands only in IDLE and ignores changes afterwards.
- REQ-025 Request withdrawn after grant: the access still completes and ack still pulses.
- REQ-026 cpustate changing to 2'b00 during a CPU access: the access completes; no new CPU grant afterwards.
- REQ-027 cpu_ack and pnl_ack SHALL never be high in the same cycle; mem_rd and mem_wr SHALL never be high together.
- REQ-028 conflict_cnt SHALL increment by 1 per IDLE cycle with both eligible requests and hold at 8'hFF.
- REQ-029 mem_addr/mem_wdata SHALL hold the last latched values outside ACCESS.

Reset
- REQ-030 On rst high at a clock edge, regardless of state: FSM=IDLE; all ack, mem_rd, mem_wr, busy = 0; mem_addr, mem_wdata, rdata, conflict_cnt = 0; last_owner = panel.
- REQ-031 Reset in ACCESS or DONE SHALL abort the transfer with no ack issued.

Verification
- REQ-032 Panel write: cpustate=00, pnl_req=1, pnl_we=1, addr=16'h0010, wdata=8'hA5 -> mem_wr=1 with those values in cycle N+1, pnl_ack=1 in N+2, cpu_req ignored throughout.
- REQ-033 CPU read: cpustate=10, cpu_req=1, addr=16'h0003, RAM returns 8'h3C -> mem_rd=1 in N+1, cpu_ack=1 with rdata=8'h3C in N+2.
- REQ-034 Tie: both requests held continuously from reset -> grants alternate CPU, panel, CPU, ... with ack every 3 cycles; conflict_cnt increments once per grant.
- REQ-035 Halt gating: cpustate=00, cpu_req=1 only, for 10 cycles -> no mem_rd/mem_wr, busy=0; switch cpustate to 01 -> cpu_ack 2 cycles later.
- REQ-036 Reset mid-access: assert rst in ACCESS cycle -> next cycle all outputs zero, no ack, FSM IDLE.
- REQ-037 Saturation: hold both requests for >800 cycles -> conflict_cnt stops at 8'hFF.
